// File: rtl/seg7_scan_controller_if.sv
// Bus bundle for seg7_scan_controller: display content, load strobe and
// brightness in, multiplexed common-anode drive and frame pulse out.
interface seg7_scan_controller_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic                load;
    logic [BRIGHT_W-1:0] brightness;
    logic [DIGITS-1:0]   anodes;
    logic [6:0]          seg;
    logic                dp;
    logic                frame_done;

    modport master (
        output data, dp_in, blank, load, brightness,
        input  anodes, seg, dp, frame_done
    );

    modport slave (
        input  data, dp_in, blank, load, brightness,
        output anodes, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// Multiplexed N-digit hex seven-segment scan controller (common anode,
// active-low drive) with per-digit dp/blanking, PWM brightness and
// frame-synchronous double-buffered content update.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_controller #(
    parameter int DIGITS   = 8,
    parameter int CLK_DIV  = 100000,
    parameter int BRIGHT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    seg7_scan_controller_if.slave  bus
);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(CLK_DIV - 1);

    // Active-low {a,b,c,d,e,f,g} pattern for a hex nibble, 'b'/'d' lowercase.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h01;
            4'h1:    hex_decode = 7'h4F;
            4'h2:    hex_decode = 7'h12;
            4'h3:    hex_decode = 7'h06;
            4'h4:    hex_decode = 7'h4C;
            4'h5:    hex_decode = 7'h24;
            4'h6:    hex_decode = 7'h20;
            4'h7:    hex_decode = 7'h0F;
            4'h8:    hex_decode = 7'h00;
            4'h9:    hex_decode = 7'h04;
            4'hA:    hex_decode = 7'h08;
            4'hB:    hex_decode = 7'h60;
            4'hC:    hex_decode = 7'h31;
            4'hD:    hex_decode = 7'h42;
            4'hE:    hex_decode = 7'h30;
            4'hF:    hex_decode = 7'h38;
            default: hex_decode = 7'h7F;
        endcase
    endfunction

    logic [PRESC_W-1:0]  presc_r;
    logic [IDX_W-1:0]    idx_r;
    logic [BRIGHT_W-1:0] pwm_r;
    logic                frame_done_r;

    logic [4*DIGITS-1:0] pend_data_r;
    logic [DIGITS-1:0]   pend_dp_r;
    logic [DIGITS-1:0]   pend_blank_r;
    logic                pend_valid_r;
    logic [4*DIGITS-1:0] act_data_r;
    logic [DIGITS-1:0]   act_dp_r;
    logic [DIGITS-1:0]   act_blank_r;

    logic [DIGITS-1:0]   anodes_r;
    logic [6:0]          seg_r;
    logic                dp_r;

    logic                tick_s;
    logic                wrap_s;
    logic [BRIGHT_W-1:0] pwm_nxt_s;
    logic [DIGITS-1:0]   auto_blank_s;
    logic [3:0]          nib_s;
    logic                dark_s;
    logic                lit_s;
    logic [DIGITS-1:0]   anodes_nxt_s;
    logic [6:0]          seg_nxt_s;
    logic                dp_nxt_s;

    assign tick_s    = (presc_r == LAST_PRESC);
    assign wrap_s    = tick_s && (idx_r == LAST_IDX);
    // The anode register loads on the same edge the pwm counter steps, so
    // compare against the pwm value that will be live while the anode is.
    assign pwm_nxt_s = pwm_r + BRIGHT_W'(1);

    // Prescaler, digit index, pwm counter and the frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r      <= '0;
            idx_r        <= '0;
            pwm_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            presc_r      <= tick_s ? '0 : presc_r + PRESC_W'(1);
            if (tick_s) begin
                idx_r <= wrap_s ? '0 : idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            pwm_r        <= pwm_nxt_s;
            frame_done_r <= wrap_s;
        end
    end

    // Pending/active double buffer; active only changes at the frame wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_data_r  <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '0;
            pend_valid_r <= 1'b0;
            act_data_r   <= '0;
            act_dp_r     <= '0;
            act_blank_r  <= '0;
        end else begin
            if (wrap_s && pend_valid_r) begin
                act_data_r  <= pend_data_r;
                act_dp_r    <= pend_dp_r;
                act_blank_r <= pend_blank_r;
            end else begin
                act_data_r  <= act_data_r;
                act_dp_r    <= act_dp_r;
                act_blank_r <= act_blank_r;
            end
            // A load on the wrapping tick lands in pending after the old
            // pending moved to active, so the valid flag stays set.
            if (bus.load) begin
                pend_data_r  <= bus.data;
                pend_dp_r    <= bus.dp_in;
                pend_blank_r <= bus.blank;
                pend_valid_r <= 1'b1;
            end else begin
                pend_valid_r <= wrap_s ? 1'b0 : pend_valid_r;
            end
        end
    end

`ifdef SEG7_LZB_EN
    logic lead_s;

    // Mark digits above the most significant nonzero active nibble.
    always_comb begin
        auto_blank_s = '0;
        lead_s       = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_s          = lead_s & (act_data_r[4*i +: 4] == 4'h0);
            auto_blank_s[i] = lead_s;
        end
    end
`else
    assign auto_blank_s = '0;
`endif

    // Next-state values of the display drive for the current digit.
    always_comb begin
        nib_s        = act_data_r[{idx_r, 2'b00} +: 4];
        dark_s       = act_blank_r[idx_r] | auto_blank_s[idx_r];
        // presc_r == 0 marks the first clk of a slot: keep all anodes off.
        lit_s        = !dark_s && (presc_r != '0) && (pwm_nxt_s <= bus.brightness);
        anodes_nxt_s = '1;
        anodes_nxt_s[idx_r] = ~lit_s;
        seg_nxt_s    = dark_s ? 7'h7F : hex_decode(nib_s);
        dp_nxt_s     = dark_s | ~act_dp_r[idx_r];
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes_r <= '1;
            seg_r    <= 7'h7F;
            dp_r     <= 1'b1;
        end else begin
            anodes_r <= anodes_nxt_s;
            seg_r    <= seg_nxt_s;
            dp_r     <= dp_nxt_s;
        end
    end

    assign bus.anodes     = anodes_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;

endmodule
